// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter states,
// branch op codes and the saturating counter update.
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } cnt_e;

   localparam logic [5:0] OP_BEQ  = 6'b010110;
   localparam logic [5:0] OP_BNE  = 6'b010111;
   localparam logic [5:0] OP_BLEZ = 6'b011000;
   localparam logic [5:0] OP_BGTZ = 6'b011001;
   localparam logic [5:0] OP_BGEZ = 6'b011010;

   function automatic logic is_branch_op(input logic [5:0] op);
      logic r;
      case (op)
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ: r = 1'b1;
         default:                                   r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic cnt_e sat_update(input cnt_e c, input logic taken);
      logic [1:0] v;
      v = c;
      if (taken && v != 2'b11)
         v = v + 2'd1;
      else if (!taken && v != 2'b00)
         v = v - 2'd1;
      return cnt_e'(v);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/resolve/flush signal bundle between the pipeline and the predictor.
interface branch_predictor_if;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        resolve_valid;
   logic [5:0]  resolve_op;
   logic [31:0] resolve_pc;
   logic        resolve_taken;
   logic [31:0] resolve_target;
   logic        resolve_pred;
   logic        mispredict;
   logic [31:0] redirect_pc;

   modport master (
      output fetch_valid, fetch_pc,
      output resolve_valid, resolve_op, resolve_pc, resolve_taken, resolve_target, resolve_pred,
      input  pred_valid, pred_taken, pred_target, mispredict, redirect_pc
   );

   modport slave (
      input  fetch_valid, fetch_pc,
      input  resolve_valid, resolve_op, resolve_pc, resolve_taken, resolve_target, resolve_pred,
      output pred_valid, pred_taken, pred_target, mispredict, redirect_pc
   );
endinterface

// File: rtl/branch_predictor_btb_array.sv
// BTB storage: one combinational read port for lookup and one
// read-modify-write update port that applies the counter/allocate rules.
module btb_array
   import branch_predictor_pkg::*;
#(
   parameter  int ENTRIES = 16,
   localparam int IDX_W   = $clog2(ENTRIES),
   localparam int TAG_W   = 30 - IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic             o_rd_valid,
   output logic [TAG_W-1:0] o_rd_tag,
   output logic [31:0]      o_rd_target,
   output cnt_e             o_rd_cnt,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [TAG_W-1:0] i_wr_tag,
   input  logic             i_wr_taken,
   input  logic [31:0]      i_wr_target
);

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   cnt_e             r_cnt    [ENTRIES];
   logic             w_wr_hit;

   assign o_rd_valid  = r_valid[i_rd_idx];
   assign o_rd_tag    = r_tag[i_rd_idx];
   assign o_rd_target = r_target[i_rd_idx];
   assign o_rd_cnt    = r_cnt[i_rd_idx];

   assign w_wr_hit = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);

   // A not-taken miss leaves the entry alone; a taken miss evicts whatever is there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= CNT_WNT;
         end
      end else if (i_wr_en) begin
         if (w_wr_hit) begin
            r_cnt[i_wr_idx] <= sat_update(r_cnt[i_wr_idx], i_wr_taken);
            if (i_wr_taken)
               r_target[i_wr_idx] <= i_wr_target;
         end else if (i_wr_taken) begin
            r_valid[i_wr_idx]  <= 1'b1;
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
            r_cnt[i_wr_idx]    <= CNT_WT;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped BTB: registered 1-cycle
// lookup, execute-stage training and a registered mispredict/redirect.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bus
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic             w_rd_valid;
   logic [TAG_W-1:0] w_rd_tag;
   logic [31:0]      w_rd_target;
   cnt_e             w_rd_cnt;
   logic [1:0]       w_rd_cnt_bits;
   logic             w_hit;
   logic             w_upd;
   logic             w_flush;

   logic             r_pred_valid;
   logic             r_pred_taken;
   logic [31:0]      r_pred_target;
   logic             r_mispredict;
   logic [31:0]      r_redirect_pc;

   btb_array #(.ENTRIES(ENTRIES)) u_btb (
      .clk         (clk),
      .rst         (rst),
      .i_rd_idx    (bus.fetch_pc[IDX_W+1:2]),
      .o_rd_valid  (w_rd_valid),
      .o_rd_tag    (w_rd_tag),
      .o_rd_target (w_rd_target),
      .o_rd_cnt    (w_rd_cnt),
      .i_wr_en     (w_upd),
      .i_wr_idx    (bus.resolve_pc[IDX_W+1:2]),
      .i_wr_tag    (bus.resolve_pc[31:IDX_W+2]),
      .i_wr_taken  (bus.resolve_taken),
      .i_wr_target (bus.resolve_target)
   );

   assign w_rd_cnt_bits = w_rd_cnt;
   assign w_hit   = w_rd_valid && (w_rd_tag == bus.fetch_pc[31:IDX_W+2]);
   assign w_upd   = bus.resolve_valid && is_branch_op(bus.resolve_op);
   assign w_flush = w_upd && (bus.resolve_pred != bus.resolve_taken);

   // A flush issued this edge kills the lookup captured on the same edge (wrong path).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pred_valid  <= 1'b0;
         r_pred_taken  <= 1'b0;
         r_pred_target <= '0;
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         r_pred_valid  <= bus.fetch_valid && !w_flush;
         r_pred_taken  <= w_hit && w_rd_cnt_bits[1];
         r_pred_target <= w_hit ? w_rd_target : bus.fetch_pc + 32'd4;
         r_mispredict  <= w_flush;
         if (!w_flush)
            r_redirect_pc <= '0;
         else if (bus.resolve_taken)
            r_redirect_pc <= bus.resolve_target;
         else
            r_redirect_pc <= bus.resolve_pc + 32'd4;
      end
   end

   assign bus.pred_valid  = r_pred_valid;
   assign bus.pred_taken  = r_pred_taken;
   assign bus.pred_target = r_pred_target;
   assign bus.mispredict  = r_mispredict;
   assign bus.redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed + randomized bench for branch_predictor against an array-based
// behavioural model of the BTB and its prediction/flush rules.
module tb_branch_predictor;

   localparam int N    = 16;
   localparam int LOGN = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   branch_predictor_if bus ();

   branch_predictor #(.ENTRIES(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // behavioural model
   bit          m_valid [N];
   logic [31:0] m_tag   [N];
   logic [31:0] m_tgt   [N];
   int          m_cnt   [N];

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc >> (2 + LOGN);
   endfunction

   function automatic bit is_br(input logic [5:0] op);
      return (op == 6'b010110) || (op == 6'b010111) || (op == 6'b011000) ||
             (op == 6'b011001) || (op == 6'b011010);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_cnt[i]   = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: expectations come from the model before it trains.
   task automatic cyc(input bit fv, input logic [31:0] fpc,
                      input bit rv, input logic [5:0] op, input logic [31:0] rpc,
                      input bit rt, input logic [31:0] rtgt, input bit rp);
      int          fi, ri;
      bit          hit, br, e_pv, e_pt, e_mp;
      logic [31:0] e_ptg, e_rd;
      bus.fetch_valid    = fv;
      bus.fetch_pc       = fpc;
      bus.resolve_valid  = rv;
      bus.resolve_op     = op;
      bus.resolve_pc     = rpc;
      bus.resolve_taken  = rt;
      bus.resolve_target = rtgt;
      bus.resolve_pred   = rp;
      fi    = idx_of(fpc);
      hit   = m_valid[fi] && (m_tag[fi] == tag_of(fpc));
      br    = rv && is_br(op);
      e_mp  = br && (rp != rt);
      e_pv  = fv && !e_mp;
      e_pt  = hit && (m_cnt[fi] >= 2);
      e_ptg = hit ? m_tgt[fi] : fpc + 32'd4;
      e_rd  = e_mp ? (rt ? rtgt : rpc + 32'd4) : 32'd0;
      if (br) begin
         ri = idx_of(rpc);
         if (m_valid[ri] && m_tag[ri] == tag_of(rpc)) begin
            m_cnt[ri] = rt ? ((m_cnt[ri] == 3) ? 3 : m_cnt[ri] + 1)
                           : ((m_cnt[ri] == 0) ? 0 : m_cnt[ri] - 1);
            if (rt) m_tgt[ri] = rtgt;
         end else if (rt) begin
            m_valid[ri] = 1'b1;
            m_tag[ri]   = tag_of(rpc);
            m_tgt[ri]   = rtgt;
            m_cnt[ri]   = 2;
         end
      end
      @(posedge clk);
      #1;
      chk("pred_valid", 32'(bus.pred_valid), 32'(e_pv));
      chk("mispredict", 32'(bus.mispredict), 32'(e_mp));
      chk("redirect_pc", bus.redirect_pc, e_rd);
      if (e_pv) begin
         chk("pred_taken", 32'(bus.pred_taken), 32'(e_pt));
         chk("pred_target", bus.pred_target, e_ptg);
      end
   endtask

   task automatic look(input logic [31:0] pc);
      cyc(1'b1, pc, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic resolve(input logic [5:0] op, input logic [31:0] pc, input bit t,
                          input logic [31:0] tgt, input bit p);
      cyc(1'b0, 32'd0, 1'b1, op, pc, t, tgt, p);
   endtask

   localparam logic [5:0] BEQ = 6'b010110;
   localparam logic [5:0] BNE = 6'b010111;

   logic [31:0] pool [8];
   bit          exp_seq [7];

   initial begin
      logic [31:0] pc, rpc;
      logic [5:0]  op;
      pool = '{32'h00400010, 32'h00400050, 32'h00400020, 32'h00401020,
               32'h0040003C, 32'hFFFFFFFC, 32'h10000000, 32'h00400044};
      exp_seq = '{1, 1, 1, 1, 1, 0, 0};
      model_reset();
      cyc(1'b0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      // reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
      chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
      chk("rst_pred_target", bus.pred_target, 32'd0);
      chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
      chk("rst_redirect", bus.redirect_pc, 32'd0);
      rst = 1'b0;

      // cold lookup misses
      look(32'h00400010);
      chk("cold_taken", 32'(bus.pred_taken), 32'd0);
      chk("cold_target", bus.pred_target, 32'h00400014);

      // taken BEQ mispredict allocates
      resolve(BEQ, 32'h00400010, 1'b1, 32'h00400100, 1'b0);
      chk("beq_mispredict", 32'(bus.mispredict), 32'd1);
      chk("beq_redirect", bus.redirect_pc, 32'h00400100);
      look(32'h00400010);
      chk("alloc_taken", 32'(bus.pred_taken), 32'd1);
      chk("alloc_target", bus.pred_target, 32'h00400100);

      // saturation up then down
      for (int i = 0; i < 7; i++) begin
         resolve(BNE, 32'h00400040, (i < 4), 32'h00400200, 1'b1);
         look(32'h00400040);
         chk("sat_taken", 32'(bus.pred_taken), 32'(exp_seq[i]));
      end

      // same-cycle lookup/update on index 4: old counter first (WT), then WNT
      cyc(1'b1, 32'h00400010, 1'b1, BEQ, 32'h00400010, 1'b0, 32'd0, 1'b1);
      chk("rbw_old", 32'(bus.pred_taken), 32'd1);
      look(32'h00400010);
      chk("rbw_new", 32'(bus.pred_taken), 32'd0);

      // non-branch op is ignored; +4 wraps
      resolve(6'b000000, 32'h00400080, 1'b1, 32'h00001234, 1'b0);
      chk("nop_mispredict", 32'(bus.mispredict), 32'd0);
      look(32'h00400080);
      chk("nop_no_alloc", 32'(bus.pred_taken), 32'd0);
      resolve(BNE, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b1);
      chk("wrap_mispredict", 32'(bus.mispredict), 32'd1);
      chk("wrap_redirect", bus.redirect_pc, 32'h00000000);

      // reset while a flush is pending
      resolve(BEQ, 32'h00400100, 1'b1, 32'h00400300, 1'b0);
      bus.resolve_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_mispredict", 32'(bus.mispredict), 32'd0);
      chk("rst_mid_redirect", bus.redirect_pc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      look(32'h00400010);
      chk("post_rst_miss0", 32'(bus.pred_taken), 32'd0);
      look(32'h00400100);
      chk("post_rst_miss1", bus.pred_target, 32'h00400104);

      // randomized traffic over a small aliasing PC pool
      for (int i = 0; i < 600; i++) begin
         pc  = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
         rpc = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
         op  = ($urandom_range(0, 3) != 0) ? 6'(6'b010110 + 6'($urandom_range(0, 4)))
                                           : 6'($urandom_range(0, 63));
         cyc(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)), op, rpc,
             1'($urandom_range(0, 1)), $urandom & 32'hFFFFFFFC, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning the number of branch target buffer (BTB) entries; it SHALL be a power of two.
REQ-002 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-004 SHALL have port fetch_valid, input, width 1: a fetch lookup request this cycle.
REQ-005 SHALL have port fetch_pc, input, width 32: the address of the fetched instruction.
REQ-006 SHALL have port pred_valid, output, width 1: the prediction outputs are valid; registered.
REQ-007 SHALL have port pred_taken, output, width 1: predict taken; registered.
REQ-008 SHALL have port pred_target, output, width 32: the predicted target address; registered.
REQ-009 SHALL have port resolve_valid, input, width 1: a branch resolved in the execute stage this cycle.
REQ-010 SHALL have port resolve_op, input, width 6: the branch compare select code (BEQ 010110, BNE 010111, BLEZ 011000, BGTZ 011001, BGEZ 011010).
REQ-011 SHALL have port resolve_pc, input, width 32: the address of the resolved branch.
REQ-012 SHALL have port resolve_taken, input, width 1: the actual outcome (the compare unit "zero" result).
REQ-013 SHALL have port resolve_target, input, width 32: the computed branch target.
REQ-014 SHALL have port resolve_pred, input, width 1: the pred_taken value that accompanied this branch down the pipe.
REQ-015 SHALL have port mispredict, output, width 1: a one-cycle flush request; registered.
REQ-016 SHALL have port redirect_pc, output, width 32: the correct next PC when mispredict=1; registered.

Function
REQ-017 SHALL index the BTB with pc[log2(ENTRIES)+1:2] and tag it with pc[31:log2(ENTRIES)+2]; pc[1:0] SHALL be ignored.
REQ-018 Each entry SHALL hold: valid, tag, target[31:0], and a 2-bit counter (SNT=00, WNT=01, WT=10, ST=11).
REQ-019 Lookup latency SHALL be 1 cycle: fetch_valid at edge N produces pred_valid=1 after edge N+1, held for exactly one cycle unless fetch_valid is held.
REQ-020 A hit (valid and tag match) SHALL give pred_taken = counter[1] and pred_target = entry target.
REQ-021 A miss SHALL give pred_taken=0 and pred_target=fetch_pc+4.
REQ-022 Only a resolve_valid with resolve_op in the five branch codes SHALL update state; any other op SHALL be ignored, including for mispredict.
REQ-023 On a hit, the counter SHALL increment when taken and decrement when not taken, saturating at 11 and 00; target SHALL be overwritten only when taken.
REQ-024 On a miss with taken=1, the entry SHALL be allocated (replacing any occupant): valid=1, tag, target, counter=WT.
REQ-025 On a miss with taken=0, no allocation SHALL occur.
REQ-026 mispredict SHALL assert one cycle after a qualifying resolve where resolve_pred != resolve_taken.
REQ-027 redirect_pc SHALL be resolve_target when taken and resolve_pc+4 when not taken; +4 SHALL wrap modulo 2^32.
REQ-028 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return the pre-update contents (read-before-write).
REQ-029 When mispredict asserts, pred_valid SHALL be forced to 0 in that same cycle (wrong-path lookup dropped).
REQ-030 mispredict and redirect_pc SHALL be 0 when not asserting a flush.

Reset
REQ-031 rst SHALL asynchronously clear all valid bits, set all counters to WNT and zero all tags and targets.
REQ-032 rst SHALL drive pred_valid=0, pred_taken=0, pred_target=0, mispredict=0 and redirect_pc=0.
REQ-033 Reset asserted mid-operation SHALL abort any pending prediction or flush; the first cycle after deassertion SHALL see only the inputs of that cycle.

Structure
REQ-034 Counter state encodings, the branch op codes and the saturating-update function SHALL live in a shared package reused by the comparison and decode logic.
REQ-035 The BTB storage array SHALL be a sub-module btb_array with one read port and one write port.

Verification
REQ-036 After reset, lookup 0x00400010 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x00400014.
REQ-037 Resolve BEQ pc=0x00400010, taken, target 0x00400100, pred=0 -> mispredict=1, redirect_pc=0x00400100; the next lookup of 0x00400010 -> pred_taken=1, target 0x00400100.
REQ-038 Four taken resolves then three not-taken on one pc -> counter 11 then 00; predictions follow counter[1] each step.
REQ-039 Lookup and update to index 4 in the same cycle -> the lookup shows the old counter; a lookup the following cycle shows the new counter.
REQ-040 resolve_op=000000 with taken=1 and pred=0 -> no mispredict and no BTB change; resolve_pc=0xFFFFFFFC, not taken, pred=1 -> redirect_pc=0x00000000.
REQ-041 rst pulsed while mispredict is pending -> mispredict=0, and all entries miss afterwards.
